// File: rtl/pll_reset_sequencer.sv
// Reset/lock sequencer for a PLLE2_ADV: pulses PLL RST, waits for continuously
// stable lock, then releases the downstream system reset; retries, sticky FAIL.
module pll_reset_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 16,
    parameter int RETRY_W      = 2
) (
    input  logic               clk,
    input  logic               cpu_reset_n,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count
);
    localparam int SYNC_STAGES = 2;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   locked_sync;
    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [RETRY_W-1:0]     retry_reg, retry_next;

    // pll_locked comes from the PLL's own lock detector, asynchronous to clk.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_sync = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        if (restart) begin
            state_next = ST_RESET_PLL;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                ST_RESET_PLL: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_sync) begin
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retry_reg == RETRY_MAX) begin
                            state_next = ST_FAIL;
                        end else begin
                            state_next = ST_RESET_PLL;
                            retry_next = retry_reg + RETRY_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    // A dropout restarts the timeout but is not a retry.
                    if (!locked_sync) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!locked_sync) begin
                        state_next = ST_RESET_PLL;
                        cnt_next   = '0;
                        retry_next = '0;
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_RESET_PLL;
                    cnt_next   = '0;
                    retry_next = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_reg <= ST_RESET_PLL;
            cnt_reg   <= '0;
            retry_reg <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            retry_reg <= retry_next;
            pll_rst   <= (state_next == ST_RESET_PLL) || (state_next == ST_FAIL);
            sys_reset <= (state_next != ST_RUN);
            ready     <= (state_next == ST_RUN);
            fail      <= (state_next == ST_FAIL);
        end
    end

    assign retry_count = retry_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed vector table for the lock scenarios,
// then randomized lock/restart/reset traffic against a time-based reference model.
module tb_pll_reset_sequencer;
    localparam int RST_CYCLES   = 16;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 1024;
    localparam int MAX_RETRIES  = 3;
    localparam int CNT_W        = 16;
    localparam int RETRY_W      = 2;
    localparam int RND_CYCLES   = 8000;

    logic               clk = 1'b0;
    logic               cpu_reset_n = 1'b0;
    logic               pll_locked = 1'b0;
    logic               restart = 1'b0;
    logic               pll_rst;
    logic               sys_reset;
    logic               ready;
    logic               fail;
    logic [RETRY_W-1:0] retry_count;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_RETRIES (MAX_RETRIES),
        .CNT_W       (CNT_W),
        .RETRY_W     (RETRY_W)
    ) dut (
        .clk        (clk),
        .cpu_reset_n(cpu_reset_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: tracks time stamps (edges since reset release) of
    // when the current PLL reset ends, when the lock wait times out and
    // when the current stable-lock run began.
    int m_n;
    int m_rst_end;
    int m_deadline;
    int m_stab_at;
    int m_retries;
    bit m_run;
    bit m_fail;
    bit m_hist[$];

    function automatic void m_attempt();
        m_rst_end  = m_n + RST_CYCLES;
        m_deadline = m_rst_end + LOCK_TIMEOUT;
        m_stab_at  = -1;
        m_run      = 1'b0;
        m_fail     = 1'b0;
    endfunction

    function automatic void m_reset();
        m_n = 0;
        m_hist.delete();
        m_retries = 0;
        m_attempt();
    endfunction

    function automatic void m_step(input bit lk, input bit rs);
        bit ls;
        m_n++;
        // lock as seen by the decision logic: the sample taken two edges ago
        ls = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 1'b0;
        m_hist.push_back(lk);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        if (rs) begin
            m_retries = 0;
            m_attempt();
        end else if (m_fail) begin
        end else if (m_run) begin
            if (!ls) begin
                m_retries = 0;
                m_attempt();
            end
        end else if (m_n <= m_rst_end) begin
        end else if (m_stab_at < 0) begin
            if (ls) begin
                m_stab_at = m_n;
            end else if (m_n == m_deadline) begin
                if (m_retries == MAX_RETRIES) begin
                    m_fail = 1'b1;
                end else begin
                    m_retries++;
                    m_attempt();
                end
            end
        end else begin
            if (!ls) begin
                m_stab_at  = -1;
                m_deadline = m_n + LOCK_TIMEOUT;
            end else if (m_n == m_stab_at + LOCK_STABLE) begin
                m_run = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (cpu_reset_n) m_step(pll_locked, restart);
        else m_reset();
        #1;
    endtask

    task automatic check(input string nm, input bit ep, input bit es, input bit er,
                         input bit ef, input int ert, input bit verbose);
        total++;
        if (pll_rst !== ep || sys_reset !== es || ready !== er || fail !== ef ||
            retry_count !== RETRY_W'(ert)) begin
            bad++;
            $display("FAIL %s t=%0t: got pll_rst=%0b sys_reset=%0b ready=%0b fail=%0b retry=%0d, expected %0b %0b %0b %0b %0d",
                     nm, $time, pll_rst, sys_reset, ready, fail, retry_count, ep, es, er, ef, ert);
        end else if (verbose) begin
            $display("ok   %s: pll_rst=%0b sys_reset=%0b ready=%0b fail=%0b retry=%0d",
                     nm, pll_rst, sys_reset, ready, fail, retry_count);
        end
    endtask

    task automatic model_check(input string nm);
        bit ep, es, er, ef;
        if (m_fail) begin
            ep = 1; es = 1; er = 0; ef = 1;
        end else if (m_run) begin
            ep = 0; es = 0; er = 1; ef = 0;
        end else if (m_n < m_rst_end) begin
            ep = 1; es = 1; er = 0; ef = 0;
        end else begin
            ep = 0; es = 1; er = 0; ef = 0;
        end
        check(nm, ep, es, er, ef, m_retries, 1'b0);
    endtask

    typedef struct {
        string name;
        int    cycles;
        bit    lock;
        bit    rs;
        bit    ep, es, er, ef;
        int    ert;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input int cyc, input bit lk, input bit rs,
                                input bit ep, input bit es, input bit er, input bit ef,
                                input int ert);
        vec_t v;
        v.name = nm; v.cycles = cyc; v.lock = lk; v.rs = rs;
        v.ep = ep; v.es = es; v.er = er; v.ef = ef; v.ert = ert;
        vecs.push_back(v);
    endfunction

    task automatic run_seg(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                pll_locked = vecs[i].lock;
                restart    = (c == 0) ? vecs[i].rs : 1'b0;
                tick();
            end
            restart = 1'b0;
            check(vecs[i].name, vecs[i].ep, vecs[i].es, vecs[i].er, vecs[i].ef,
                  vecs[i].ert, 1'b1);
        end
    endtask

    initial begin
        int seg_a, seg_b, seg_c, seg_end;
        int rnd_bad0, cyc, len;
        bit lvl;

        // clean lock, then a one-clock loss of lock in RUN and re-lock
        seg_a = vecs.size();
        add("clean_rst_hold",    15, 0, 0, 1, 1, 0, 0, 0);
        add("clean_rst_fall",     1, 0, 0, 0, 1, 0, 0, 0);
        add("clean_wait",        10, 0, 0, 0, 1, 0, 0, 0);
        add("clean_lock_pre",    10, 1, 0, 0, 1, 0, 0, 0);
        add("clean_ready",        1, 1, 0, 0, 0, 1, 0, 0);
        add("run_hold",           5, 1, 0, 0, 0, 1, 0, 0);
        add("lol_drop",           1, 0, 0, 0, 0, 1, 0, 0);
        add("lol_plus1",          1, 1, 0, 0, 0, 1, 0, 0);
        add("lol_plus2",          1, 1, 0, 1, 1, 0, 0, 0);
        add("lol_rst_hold",      15, 1, 0, 1, 1, 0, 0, 0);
        add("lol_rst_fall",       1, 1, 0, 0, 1, 0, 0, 0);
        add("relock_pre",         8, 1, 0, 0, 1, 0, 0, 0);
        add("relock_ready",       1, 1, 0, 0, 0, 1, 0, 0);
        // glitchy lock after a restart
        seg_b = vecs.size();
        add("glitch_restart",     1, 0, 1, 1, 1, 0, 0, 0);
        add("glitch_rst_hold",   15, 0, 0, 1, 1, 0, 0, 0);
        add("glitch_rst_fall",    1, 0, 0, 0, 1, 0, 0, 0);
        add("glitch_hi",          5, 1, 0, 0, 1, 0, 0, 0);
        add("glitch_lo",          3, 0, 0, 0, 1, 0, 0, 0);
        add("glitch_relock_pre", 10, 1, 0, 0, 1, 0, 0, 0);
        add("glitch_ready",       1, 1, 0, 0, 0, 1, 0, 0);
        // no lock until FAIL, then restart out of FAIL
        seg_c = vecs.size();
        add("nolock_restart",     1, 0, 1, 1, 1, 0, 0, 0);
        add("nolock_wait1",    1039, 0, 0, 0, 1, 0, 0, 0);
        add("nolock_retry1",      1, 0, 0, 1, 1, 0, 0, 1);
        add("nolock_wait2",    1039, 0, 0, 0, 1, 0, 0, 1);
        add("nolock_retry2",      1, 0, 0, 1, 1, 0, 0, 2);
        add("nolock_wait3",    1039, 0, 0, 0, 1, 0, 0, 2);
        add("nolock_retry3",      1, 0, 0, 1, 1, 0, 0, 3);
        add("nolock_wait4",    1039, 0, 0, 0, 1, 0, 0, 3);
        add("nolock_fail",        1, 0, 0, 1, 1, 0, 1, 3);
        add("fail_hold",       2000, 0, 0, 1, 1, 0, 1, 3);
        add("fail_restart",       1, 0, 1, 1, 1, 0, 0, 0);
        add("fail_rst_hold",     15, 0, 0, 1, 1, 0, 0, 0);
        add("fail_rst_fall",      1, 0, 0, 0, 1, 0, 0, 0);
        add("fail_lock_pre",     10, 1, 0, 0, 1, 0, 0, 0);
        add("fail_ready",         1, 1, 0, 0, 0, 1, 0, 0);
        seg_end = vecs.size();

        repeat (3) tick();
        check("reset_state", 1, 1, 0, 0, 0, 1'b1);
        cpu_reset_n = 1'b1;

        run_seg(seg_a, seg_b);
        run_seg(seg_b, seg_c);
        run_seg(seg_c, seg_end);

        // async reset while in STABLE, then a clean sequence again
        pll_locked = 1'b1;
        restart    = 1'b1;
        tick();
        restart = 1'b0;
        repeat (20) tick();
        check("async_pre_stable", 0, 1, 0, 0, 0, 1'b1);
        #3 cpu_reset_n = 1'b0;
        m_reset();
        #1 check("async_assert", 1, 1, 0, 0, 0, 1'b1);
        tick();
        check("async_held", 1, 1, 0, 0, 0, 1'b1);
        pll_locked = 1'b0;
        #2 cpu_reset_n = 1'b1;
        run_seg(seg_a, seg_b);

        // randomized traffic against the reference model
        rnd_bad0 = bad;
        cyc = 0;
        lvl = 1'b1;
        while (cyc < RND_CYCLES && (bad - rnd_bad0) < 10) begin
            lvl = ~lvl;
            if (!lvl && $urandom_range(0, 7) == 0) len = $urandom_range(900, 2300);
            else len = $urandom_range(1, 30);
            for (int i = 0; i < len && cyc < RND_CYCLES; i++) begin
                pll_locked = lvl;
                restart    = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 1499) == 0) begin
                    #2 cpu_reset_n = 1'b0;
                    m_reset();
                    #1 model_check("rnd_async_assert");
                    tick();
                    #2 cpu_reset_n = 1'b1;
                end
                tick();
                restart = 1'b0;
                model_check("rnd_model");
                cyc++;
            end
        end
        $display("random phase: %0d cycles compared against model", cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
